// File: rtl/btn_debouncer_if.sv
// Button debouncer bus: raw buttons in, debounced level and event pulses out.
// No valid/ready handshake: press/release_pulse/hold are single-cycle qualifiers, level is a steady state.
interface btn_debouncer_if #(
    parameter int N = 2
);
    logic [N-1:0]   btn;
    logic [N-1:0]   level;
    logic [N-1:0]   press;
    logic [N-1:0]   release_pulse;  // "release" is a reserved word
    logic [N-1:0]   hold;
    logic [2*N-1:0] state;          // per-channel FSM state, 2 bits each, for checkers

    modport master (
        output btn,
        input  level, press, release_pulse, hold, state
    );

    modport slave (
        input  btn,
        output level, press, release_pulse, hold, state
    );
endinterface

// File: rtl/btn_debouncer.sv
// N-channel button debouncer: 2-flop synchronizer, debounce FSM, press/release/hold pulses.
// Define BTN_LONG_PRESS_EN to enable the per-channel long-press (HOLD) counter.
module btn_debouncer #(
    parameter int N               = 2,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int HOLD_CYCLES     = 12000000
) (
    input logic            clk,
    input logic            rs,
    btn_debouncer_if.slave bus
);
    localparam int             CW    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  C_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
        $error("DEBOUNCE_CYCLES must be 2 or more");
    end
    if (HOLD_CYCLES < 2) begin : g_chk_hold
        $error("HOLD_CYCLES must be 2 or more");
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        state_t        st;
        logic [CW-1:0] cnt;
        logic          level_r;
        logic          press_r;
        logic          rel_r;
        logic          hold_r;

        always_ff @(posedge clk) begin
            if (rs) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= bus.btn[i];
                sync2 <= sync1;
            end
        end

        // Pulses default low each cycle, so a pulse only follows a fresh transition.
        always_ff @(posedge clk) begin
            if (rs) begin
                st      <= IDLE;
                cnt     <= '0;
                level_r <= 1'b0;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
            end else begin
                press_r <= 1'b0;
                rel_r   <= 1'b0;
                case (st)
                    IDLE: begin
                        if (sync2) begin
                            st  <= PRESS_WAIT;
                            cnt <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync2) begin
                            st <= IDLE;
                        end else if (cnt == C_MAX) begin
                            st      <= PRESSED;
                            level_r <= 1'b1;
                            press_r <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!sync2) begin
                            st  <= RELEASE_WAIT;
                            cnt <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync2) begin
                            st <= PRESSED;
                        end else if (cnt == C_MAX) begin
                            st      <= IDLE;
                            level_r <= 1'b0;
                            rel_r   <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end

`ifdef BTN_LONG_PRESS_EN
        localparam int            HW    = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
        localparam logic [HW-1:0] H_MAX = HW'(HOLD_CYCLES - 1);

        logic [HW-1:0] hcnt;
        logic          hold_done;

        // Counter restarts whenever the button is not debounced-down; it saturates at
        // H_MAX and hold_done keeps the pulse to one per press.
        always_ff @(posedge clk) begin
            if (rs) begin
                hcnt      <= '0;
                hold_done <= 1'b0;
                hold_r    <= 1'b0;
            end else begin
                hold_r <= 1'b0;
                if (st == IDLE || st == PRESS_WAIT) begin
                    hcnt      <= '0;
                    hold_done <= 1'b0;
                end else if (hcnt != H_MAX) begin
                    hcnt <= hcnt + HW'(1);
                end else if (!hold_done) begin
                    hold_r    <= 1'b1;
                    hold_done <= 1'b1;
                end
            end
        end
`else
        assign hold_r = 1'b0;
`endif

        assign bus.level[i]          = level_r;
        assign bus.press[i]          = press_r;
        assign bus.release_pulse[i]  = rel_r;
        assign bus.hold[i]           = hold_r;
        assign bus.state[2*i +: 2]   = st;
    end
endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with N=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
// Expected HOLD behaviour follows BTN_LONG_PRESS_EN.
module tb_btn_debouncer;
    logic clk;
    logic rs;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    btn_debouncer_if #(.N(2)) bus ();

    btn_debouncer #(
        .N               (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20)
    ) dut (
        .clk (clk),
        .rs  (rs),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one rising edge, then settle; outputs read here reflect "after that edge"
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0] seen_lvl, seen_prs, seen_rel;
    logic       lvl_all;
    int         rel_count, hold_count, hold_edge;
    logic [1:0] hold_val;

    initial begin
        rs      = 1'b1;
        bus.btn = 2'b00;
        tick_n(3);
        check("reset_level", {6'b0, bus.level}, 8'h00);
        check("reset_press", {6'b0, bus.press}, 8'h00);
        check("reset_release", {6'b0, bus.release_pulse}, 8'h00);
        check("reset_hold", {6'b0, bus.hold}, 8'h00);
        check("reset_state", {4'b0, bus.state}, 8'h00);
        rs = 1'b0;
        tick_n(2);

        // ch0 press: level/press rise after edge 6
        bus.btn = 2'b01;
        tick_n(6);
        check("a_level_e5", {6'b0, bus.level}, 8'h00);
        check("a_press_e5", {6'b0, bus.press}, 8'h00);
        tick();
        check("a_level_e6", {6'b0, bus.level}, 8'h01);
        check("a_press_e6", {6'b0, bus.press}, 8'h01);
        check("a_state_e6", {4'b0, bus.state}, 8'h02);
        tick();
        check("a_press_e7", {6'b0, bus.press}, 8'h00);
        check("a_level_e7", {6'b0, bus.level}, 8'h01);

        // ch0 release: symmetric latency
        bus.btn = 2'b00;
        tick_n(6);
        check("r_level_e5", {6'b0, bus.level}, 8'h01);
        check("r_release_e5", {6'b0, bus.release_pulse}, 8'h00);
        check("r_state_e5", {4'b0, bus.state}, 8'h03);
        tick();
        check("r_level_e6", {6'b0, bus.level}, 8'h00);
        check("r_release_e6", {6'b0, bus.release_pulse}, 8'h01);
        tick();
        check("r_release_e7", {6'b0, bus.release_pulse}, 8'h00);
        check("r_state_e7", {4'b0, bus.state}, 8'h00);

        // 3-cycle glitch on ch0: nothing may happen
        bus.btn = 2'b01;
        tick_n(3);
        bus.btn = 2'b00;
        seen_lvl = 2'b00;
        seen_prs = 2'b00;
        seen_rel = 2'b00;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen_lvl |= bus.level;
            seen_prs |= bus.press;
            seen_rel |= bus.release_pulse;
        end
        check("g_level", {6'b0, seen_lvl}, 8'h00);
        check("g_press", {6'b0, seen_prs}, 8'h00);
        check("g_release", {6'b0, seen_rel}, 8'h00);
        check("g_state", {4'b0, bus.state}, 8'h00);

        // pressed, 2-cycle low bounce, then held: level stays, no release
        bus.btn = 2'b01;
        tick_n(7);
        check("c_press", {6'b0, bus.press}, 8'h01);
        bus.btn = 2'b00;
        tick_n(2);
        bus.btn = 2'b01;
        lvl_all  = 1'b1;
        seen_rel = 2'b00;
        for (int k = 0; k < 10; k++) begin
            tick();
            lvl_all  &= bus.level[0];
            seen_rel |= bus.release_pulse;
        end
        check("c_level_kept", {7'b0, lvl_all}, 8'h01);
        check("c_no_release", {6'b0, seen_rel}, 8'h00);
        bus.btn   = 2'b00;
        rel_count = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.release_pulse[0]) rel_count++;
        end
        check("c_release_count", 8'(rel_count), 8'd1);
        check("c_level_end", {6'b0, bus.level}, 8'h00);

        // reset at edge 4 of a press; button held through reset
        bus.btn = 2'b01;
        tick_n(4);
        rs = 1'b1;
        tick();
        check("d_level_rst", {6'b0, bus.level}, 8'h00);
        check("d_press_rst", {6'b0, bus.press}, 8'h00);
        check("d_state_rst", {4'b0, bus.state}, 8'h00);
        rs = 1'b0;
        tick_n(6);
        check("d_press_e10", {6'b0, bus.press}, 8'h00);
        check("d_level_e10", {6'b0, bus.level}, 8'h00);
        tick();
        check("d_press_e11", {6'b0, bus.press}, 8'h01);
        check("d_level_e11", {6'b0, bus.level}, 8'h01);
        bus.btn = 2'b00;
        tick_n(10);
        check("d_idle", {4'b0, bus.state}, 8'h00);

        // both channels together, then held 40 cycles for long-press
        bus.btn = 2'b11;
        tick_n(6);
        check("e_press_e5", {6'b0, bus.press}, 8'h00);
        tick();
        check("e_press_e6", {6'b0, bus.press}, 8'h03);
        check("e_level_e6", {6'b0, bus.level}, 8'h03);
        hold_count = 0;
        hold_edge  = -1;
        hold_val   = 2'b00;
        for (int e = 7; e <= 46; e++) begin
            tick();
            if (bus.hold != 2'b00) begin
                hold_count++;
                if (hold_edge < 0) begin
                    hold_edge = e;
                    hold_val  = bus.hold;
                end
            end
        end
`ifdef BTN_LONG_PRESS_EN
        check("f_hold_count", 8'(hold_count), 8'd1);
        check("f_hold_edge", 8'(hold_edge), 8'd26);
        check("f_hold_val", {6'b0, hold_val}, 8'h03);
`else
        check("f_hold_count", 8'(hold_count), 8'd0);
        check("f_hold_val", {6'b0, hold_val}, 8'h00);
`endif
        check("f_level_held", {6'b0, bus.level}, 8'h03);
        bus.btn = 2'b00;
        tick_n(10);
        check("f_level_end", {6'b0, bus.level}, 8'h00);
        check("f_state_end", {4'b0, bus.state}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
